encoder_block_scheduler: RTL and testbench

ENCODER_BLOCK_SCHEDULER -- requirements
Module: encoder_block_scheduler

---
 rtl/encoder_block_scheduler_pkg.sv | 23 ++
 rtl/encoder_block_scheduler_byte_serializer.sv | 56 +++++
 rtl/encoder_block_scheduler.sv | 129 ++++++++++++
 tb/tb_encoder_block_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_block_scheduler_pkg.sv
// Shared types and constants for the encoder block scheduler: the FSM state
// encoding, default code-block sizes and the byte counts derived from them.
package encoder_block_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TAIL  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  localparam int K_SMALL_DEFAULT = 1056;
  localparam int K_LARGE_DEFAULT = 6144;
  localparam int BYTES_SMALL     = K_SMALL_DEFAULT / 8;  // 132
  localparam int BYTES_LARGE     = K_LARGE_DEFAULT / 8;  // 768
  localparam int BYTE_CNT_W      = 10;

  function automatic logic [BYTE_CNT_W-1:0] bytes_per_block(input int k_bits);
    return BYTE_CNT_W'(k_bits / 8);
  endfunction

endpackage

// File: rtl/encoder_block_scheduler_byte_serializer.sv
// Byte-to-bit serializer: 8-bit MSB-first shift register, 3-bit bit counter
// and a flag marking the final byte of the block.
module sched_byte_serializer (
  input  logic       clock,
  input  logic       aclr,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       load_last,
  input  logic       advance,
  output logic       bit_out,
  output logic       last_out,
  output logic       final_bit
);

  logic [7:0] shift_reg, shift_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic       last_reg, last_next;
  logic [7:0] shifted;

  genvar gi;
  assign shifted[0] = 1'b0;
  for (gi = 1; gi < 8; gi++) begin : g_shift
    assign shifted[gi] = shift_reg[gi-1];
  end

  always_comb begin
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    last_next    = last_reg;
    if (load) begin
      shift_next   = load_byte;
      bit_cnt_next = 3'd0;
      last_next    = load_last;
    end else if (advance) begin
      shift_next   = shifted;
      bit_cnt_next = bit_cnt_reg + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      shift_reg   <= 8'd0;
      bit_cnt_reg <= 3'd0;
      last_reg    <= 1'b0;
    end else begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      last_reg    <= last_next;
    end
  end

  assign bit_out   = shift_reg[7];
  assign last_out  = last_reg;
  assign final_bit = (bit_cnt_reg == 3'd7);

endmodule

// File: rtl/encoder_block_scheduler.sv
// Feeds one code block (K_SMALL or K_LARGE bits) MSB-first to a serial encoder,
// then waits out trellis termination. Optional SCHED_BLOCK_CNT_EN adds a block counter.
module encoder_block_scheduler
  import encoder_block_scheduler_pkg::*;
#(
  parameter int K_SMALL = K_SMALL_DEFAULT,
  parameter int K_LARGE = K_LARGE_DEFAULT
) (
  input  logic       clock,
  input  logic       aclr,
  input  logic       cfg_start,
  input  logic       cfg_size_sel,
  output logic       cfg_ready,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       enc_bits_in,
  output logic       enc_bits_in_valid,
  output logic       enc_in_last_bits,
  input  logic       enc_bits_in_ready,
  input  logic       enc_tail,
  output logic       block_done,
  output logic       busy
`ifdef SCHED_BLOCK_CNT_EN
  ,
  output logic [15:0] blocks_done_cnt
`endif
);

  localparam logic [BYTE_CNT_W-1:0] SMALL_BYTES = bytes_per_block(K_SMALL);
  localparam logic [BYTE_CNT_W-1:0] LARGE_BYTES = bytes_per_block(K_LARGE);

  sched_state_t            state_reg, state_next;
  logic [BYTE_CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic                    tail_seen_reg, tail_seen_next;
  logic                    ser_load, ser_advance, ser_bit, ser_last, ser_final_bit;

  sched_byte_serializer u_serializer (
    .clock     (clock),
    .aclr      (aclr),
    .load      (ser_load),
    .load_byte (byte_in),
    .load_last (byte_cnt_reg == BYTE_CNT_W'(1)),
    .advance   (ser_advance),
    .bit_out   (ser_bit),
    .last_out  (ser_last),
    .final_bit (ser_final_bit)
  );

  always_comb begin
    state_next     = state_reg;
    byte_cnt_next  = byte_cnt_reg;
    tail_seen_next = tail_seen_reg;
    ser_load       = 1'b0;
    ser_advance    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          byte_cnt_next  = cfg_size_sel ? LARGE_BYTES : SMALL_BYTES;
          tail_seen_next = 1'b0;
          state_next     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (byte_valid) begin
          ser_load      = 1'b1;
          byte_cnt_next = byte_cnt_reg - BYTE_CNT_W'(1);
          state_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (enc_bits_in_ready) begin
          ser_advance = 1'b1;
          if (ser_final_bit) begin
            state_next = (byte_cnt_reg != '0) ? ST_LOAD : ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        // Completion needs an observed rise of enc_tail followed by its fall.
        if (enc_tail) begin
          tail_seen_next = 1'b1;
        end else if (tail_seen_reg) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        tail_seen_next = 1'b0;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_reg     <= ST_IDLE;
      byte_cnt_reg  <= '0;
      tail_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_cnt_reg  <= byte_cnt_next;
      tail_seen_reg <= tail_seen_next;
    end
  end

  assign cfg_ready         = (state_reg == ST_IDLE);
  assign busy              = (state_reg != ST_IDLE);
  assign byte_ready        = (state_reg == ST_LOAD);
  assign enc_bits_in_valid = (state_reg == ST_SHIFT);
  assign enc_bits_in       = (state_reg == ST_SHIFT) & ser_bit;
  assign enc_in_last_bits  = (state_reg == ST_SHIFT) & ser_last;
  assign block_done        = (state_reg == ST_DONE);

`ifdef SCHED_BLOCK_CNT_EN
  logic [15:0] blocks_done_cnt_reg;

  always_ff @(posedge clock) begin
    if (aclr) begin
      blocks_done_cnt_reg <= 16'd0;
    end else if (block_done) begin
      blocks_done_cnt_reg <= blocks_done_cnt_reg + 16'd1;
    end
  end

  assign blocks_done_cnt = blocks_done_cnt_reg;
`endif

endmodule

// File: tb/tb_encoder_block_scheduler.sv
// Randomized scoreboard bench for encoder_block_scheduler: expected bits are
// queued at each byte handshake and checked by an independent monitor.
module tb_encoder_block_scheduler;

  logic       clock = 1'b0;
  logic       aclr = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_size_sel = 1'b0;
  logic       cfg_ready;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       enc_bits_in;
  logic       enc_bits_in_valid;
  logic       enc_in_last_bits;
  logic       enc_bits_in_ready = 1'b0;
  logic       enc_tail = 1'b0;
  logic       block_done;
  logic       busy;
`ifdef SCHED_BLOCK_CNT_EN
  logic [15:0] blocks_done_cnt;
`endif

  always #5 clock = ~clock;

  encoder_block_scheduler dut (
    .clock             (clock),
    .aclr              (aclr),
    .cfg_start         (cfg_start),
    .cfg_size_sel      (cfg_size_sel),
    .cfg_ready         (cfg_ready),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .enc_bits_in       (enc_bits_in),
    .enc_bits_in_valid (enc_bits_in_valid),
    .enc_in_last_bits  (enc_in_last_bits),
    .enc_bits_in_ready (enc_bits_in_ready),
    .enc_tail          (enc_tail),
    .block_done        (block_done),
`ifdef SCHED_BLOCK_CNT_EN
    .blocks_done_cnt   (blocks_done_cnt),
`endif
    .busy              (busy)
  );

  typedef struct {
    bit b;
    bit last;
  } exp_bit_t;

  localparam int MODE_RAND_READY = 1;
  localparam int MODE_RAND_VALID = 2;
  localparam int MODE_A5         = 4;
  localparam int MODE_INJECT     = 8;

  exp_bit_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  bits_seen = 0;
  int  done_pulses = 0;
  int  cur_k = 0;
  int  blocks_expected = 0;
  bit  tail_fell = 1'b0;
  bit  mon_en = 1'b0;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: pops one expected bit per accepted encoder transfer.
  bit stall_pending = 1'b0;
  bit stall_bit = 1'b0;
  always @(negedge clock) begin
    if (mon_en && !aclr) begin
      if (enc_bits_in_valid) begin
        if (stall_pending) check("stall_hold_bit", enc_bits_in, stall_bit);
        if (enc_bits_in_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_bit: got bit %0d at count %0d, expected none", enc_bits_in, bits_seen);
          end else begin
            exp_bit_t e;
            e = exp_q.pop_front();
            check("bit_value", enc_bits_in, e.b);
            check("last_flag", enc_in_last_bits, e.last);
            bits_seen++;
          end
          stall_pending = 1'b0;
        end else begin
          stall_pending = 1'b1;
          stall_bit = enc_bits_in;
        end
      end else begin
        stall_pending = 1'b0;
        if (enc_in_last_bits) check("last_without_valid", enc_in_last_bits, 0);
      end
      if (block_done) begin
        done_pulses++;
        check("done_after_tail_fall", tail_fell, 1);
        check("done_bit_total", bits_seen, cur_k);
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  task automatic run_block(input bit sel, input int mode, input int abort_at);
    int  nbytes;
    int  handshakes;
    int  byte_idx;
    int  tail_cnt;
    int  done0;
    bit  finished;
    bit  aborted;
    bit  injected;
    logic [7:0] cur_byte;

    cur_k      = sel ? 6144 : 1056;
    nbytes     = cur_k / 8;
    bits_seen  = 0;
    tail_fell  = 1'b0;
    handshakes = 0;
    byte_idx   = 0;
    tail_cnt   = 0;
    finished   = 1'b0;
    aborted    = 1'b0;
    injected   = 1'b0;
    done0      = done_pulses;
    cur_byte   = (mode & MODE_A5) != 0 ? 8'hA5 : 8'($urandom);

    @(negedge clock);
    check("cfg_ready_before_start", cfg_ready, 1);
    @(posedge clock); #1;
    cfg_start = 1'b1;
    cfg_size_sel = sel;
    @(posedge clock); #1;

    for (int cyc = 0; cyc < 40000 && !finished && !aborted; cyc++) begin
      cfg_start = 1'b0;
      cfg_size_sel = 1'($urandom);
      byte_valid = (mode & MODE_RAND_VALID) != 0 ? 1'($urandom) : 1'b1;
      byte_in = cur_byte;
      enc_bits_in_ready = (mode & MODE_RAND_READY) != 0 ? 1'($urandom) : 1'b1;
      if ((mode & MODE_INJECT) != 0 && bits_seen >= 300 && !injected) begin
        cfg_start = 1'b1;
        cfg_size_sel = 1'b1;
        injected = 1'b1;
      end
      if (bits_seen >= cur_k) begin
        tail_cnt++;
        enc_tail = (tail_cnt >= 3 && tail_cnt < 6);
        if (tail_cnt == 6) tail_fell = 1'b1;
      end
      if (abort_at > 0 && bits_seen >= abort_at) begin
        aclr = 1'b1;
        aborted = 1'b1;
      end
      @(negedge clock);
      if (!aborted) begin
        if (byte_valid && byte_ready) begin
          for (int i = 7; i >= 0; i--) begin
            exp_bit_t e;
            e.b = cur_byte[i];
            e.last = (byte_idx == nbytes - 1);
            exp_q.push_back(e);
          end
          byte_idx++;
          handshakes++;
          cur_byte = (mode & MODE_A5) != 0 ? 8'hA5 : 8'($urandom);
        end
        if (done_pulses != done0) finished = 1'b1;
        @(posedge clock); #1;
      end
    end

    enc_tail = 1'b0;
    cfg_start = 1'b0;
    byte_valid = 1'b0;
    enc_bits_in_ready = 1'b0;

    if (aborted) begin
      @(posedge clock); #1;
      aclr = 1'b0;
      @(negedge clock);
      check("abort_cfg_ready", cfg_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_valid", enc_bits_in_valid, 0);
      check("abort_byte_ready", byte_ready, 0);
      for (int i = 0; i < 5; i++) @(negedge clock);
      check("abort_no_done", done_pulses - done0, 0);
      exp_q.delete();
      $display("block sel=%0d mode=%0d aborted after %0d bits", sel, mode, bits_seen);
    end else begin
      check("block_finished_in_budget", finished, 1);
      @(posedge clock); #1;
      @(negedge clock);
      check("cfg_ready_after_done", cfg_ready, 1);
      check("done_deasserted", block_done, 0);
      @(negedge clock);
      check("done_pulse_count", done_pulses - done0, 1);
      check("total_bits", bits_seen, cur_k);
      check("queue_drained", exp_q.size(), 0);
      check("byte_handshakes", handshakes, nbytes);
      blocks_expected++;
      $display("block sel=%0d mode=%0d bits=%0d bytes=%0d done=%0d", sel, mode, bits_seen, handshakes, done_pulses - done0);
    end
  endtask

  initial begin
    aclr = 1'b1;
    cfg_start = 1'b1;
    byte_valid = 1'b1;
    enc_bits_in_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    cfg_start = 1'b0;
    byte_valid = 1'b0;
    enc_bits_in_ready = 1'b0;
    aclr = 1'b0;
    @(negedge clock);
    check("reset_cfg_ready", cfg_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_byte_ready", byte_ready, 0);
    check("reset_valid", enc_bits_in_valid, 0);
    check("reset_bit", enc_bits_in, 0);
    check("reset_last", enc_in_last_bits, 0);
    check("reset_done", block_done, 0);
`ifdef SCHED_BLOCK_CNT_EN
    check("reset_cnt", blocks_done_cnt, 0);
`endif
    $display("reset checks done");
    mon_en = 1'b1;

    run_block(1'b0, 0, 0);
    run_block(1'b1, MODE_A5, 0);
    run_block(1'b0, MODE_RAND_READY | MODE_RAND_VALID, 0);
    run_block(1'b0, MODE_INJECT, 0);
    run_block(1'b0, MODE_RAND_READY, 500);
`ifdef SCHED_BLOCK_CNT_EN
    check("cnt_after_abort_reset", blocks_done_cnt, 0);
    blocks_expected = 0;
`endif
    run_block(1'b0, MODE_RAND_VALID, 0);
    run_block(1'b0, 0, 0);
    run_block(1'b0, MODE_RAND_READY, 0);

`ifdef SCHED_BLOCK_CNT_EN
    check("cnt_three_blocks", blocks_done_cnt, blocks_expected);
    @(posedge clock); #1;
    force dut.blocks_done_cnt_reg = 16'hFFFF;
    @(posedge clock); #1;
    release dut.blocks_done_cnt_reg;
    run_block(1'b0, 0, 0);
    check("cnt_wrap", blocks_done_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
